uram_event_axis_packer: RTL and testbench

//  Downstream of the URAM event readout state machine. Captures the header/URAM words that machine

---
 rtl/uram_event_axis_packer.sv | 184 ++++++++++++++++++
 tb/tb_uram_event_axis_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_event_axis_packer.sv
// uram_event_axis_packer: captures header/URAM words from the event readout SM, buffers
// them in a first-word-fall-through FIFO and streams them out as AXI4-Stream events.
// Optional feature macro: UEV_PACKER_TRAILER_EN appends a trailer word
// {16'hE7E7, event_count, word_count} carrying tlast after every event (needs DATA_WIDTH >= 64).
module uram_event_axis_packer #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned START_THRESH = 4,
  parameter int unsigned HDR_WORDS    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_ce_i,
  input  logic                  evbuf_avail_i,
  output logic                  data_avail_o,
  input  logic                  valid_i,
  input  logic                  sel_header_i,
  input  logic                  complete_i,
  input  logic [DATA_WIDTH-1:0] header_dat_i,
  input  logic [DATA_WIDTH-1:0] ram_dat_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow_o,
  output logic                  framing_err_o,
  output logic [15:0]           event_count_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned EC_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVENT   = 2'd1,
    ST_TRAILER = 2'd2
  } state_e;

  // FIFO storage: bit DATA_WIDTH is tlast
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

  state_e              state_q,  state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]   fill_q,   fill_d;
  logic [WC_W-1:0]     wc_q,     wc_d;
  logic [EC_W-1:0]     ec_q,     ec_d;
  logic                ovf_q,    ovf_d;
  logic                ferr_q,   ferr_d;
`ifdef UEV_PACKER_TRAILER_EN
  logic [DATA_WIDTH-1:0] trail_q, trail_d;
`endif

  logic                cap;
  logic                full;
  logic                empty;
  logic                pop;
  logic                wr_req;
  logic                wr_en;
  logic                hdr_expected;
  logic [DATA_WIDTH:0] wr_word;

  // Capture, framing check, event bookkeeping and FIFO pointer update
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    wc_d     = wc_q;
    ec_d     = ec_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
`ifdef UEV_PACKER_TRAILER_EN
    trail_d  = trail_q;
`endif
    wr_req       = 1'b0;
    wr_word      = '0;
    cap          = clk_ce_i & valid_i;
    full         = (fill_q == FILL_W'(FIFO_DEPTH));
    empty        = (fill_q == '0);
    pop          = ~empty & m_axis_tready;
    hdr_expected = (wc_q < WC_W'(HDR_WORDS));

    if (cap) begin
      wr_req = 1'b1;
`ifdef UEV_PACKER_TRAILER_EN
      wr_word = {1'b0, (sel_header_i ? header_dat_i : ram_dat_i)};
`else
      wr_word = {complete_i, (sel_header_i ? header_dat_i : ram_dat_i)};
`endif
      if (sel_header_i != hdr_expected) begin
        ferr_d = 1'b1;
      end
      if (complete_i) begin
        wc_d = '0;
        ec_d = ec_q + EC_W'(1);
`ifdef UEV_PACKER_TRAILER_EN
        state_d = ST_TRAILER;
        trail_d = DATA_WIDTH'({16'hE7E7, ec_q, 32'({16'd0, wc_q}) + 32'd1});
`else
        state_d = ST_IDLE;
`endif
      end else begin
        wc_d    = wc_q + WC_W'(1);
        state_d = ST_EVENT;
      end
    end

`ifdef UEV_PACKER_TRAILER_EN
    // Trailer owns the write port for one cycle; a colliding capture is lost
    if (state_q == ST_TRAILER) begin
      if (cap) begin
        ovf_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
      wr_req  = 1'b1;
      wr_word = {1'b1, trail_q};
    end
`endif

    // A simultaneous pop frees a slot, so a write while full is still legal then
    wr_en = wr_req & (~full | pop);
    if (wr_req & ~wr_en) begin
      ovf_d = 1'b1;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fill_d = fill_q + FILL_W'(wr_en) - FILL_W'(pop);
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      wc_q     <= '0;
      ec_q     <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UEV_PACKER_TRAILER_EN
      trail_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      wc_q     <= wc_d;
      ec_q     <= ec_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
`ifdef UEV_PACKER_TRAILER_EN
      trail_q  <= trail_d;
`endif
    end
  end

  // FIFO storage write; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // Head word drives the stream directly (first-word fall-through), zeroed when empty
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_axis_tlast  = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_WIDTH];

  assign data_avail_o  = evbuf_avail_i & ((state_q == ST_EVENT) | (fill_q <= FILL_W'(START_THRESH)));
  assign overflow_o    = ovf_q;
  assign framing_err_o = ferr_q;
  assign event_count_o = ec_q;

endmodule

// File: tb/tb_uram_event_axis_packer.sv
// Self-checking bench for uram_event_axis_packer: randomized readout-SM style stimulus
// compared every cycle against a queue-based reference model.
// Honours UEV_PACKER_TRAILER_EN the same way as the design.
module tb_uram_event_axis_packer;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned THR   = 4;
  localparam int unsigned HDR   = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clk_ce_i = 1'b0;
  logic          evbuf_avail_i = 1'b1;
  logic          data_avail_o;
  logic          valid_i = 1'b0;
  logic          sel_header_i = 1'b0;
  logic          complete_i = 1'b0;
  logic [DW-1:0] header_dat_i = '0;
  logic [DW-1:0] ram_dat_i = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          overflow_o;
  logic          framing_err_o;
  logic [15:0]   event_count_o;

  uram_event_axis_packer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .START_THRESH(THR), .HDR_WORDS(HDR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_ce_i(clk_ce_i), .evbuf_avail_i(evbuf_avail_i),
    .data_avail_o(data_avail_o), .valid_i(valid_i), .sel_header_i(sel_header_i),
    .complete_i(complete_i), .header_dat_i(header_dat_i), .ram_dat_i(ram_dat_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .overflow_o(overflow_o), .framing_err_o(framing_err_o),
    .event_count_o(event_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  // Reference model state: the stream contents are just a bounded queue
  beat_t       q[$];
  int          m_wc = 0;
  int          m_ec = 0;
  bit          m_inev = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_ferr = 1'b0;
  bit          m_trail_pend = 1'b0;
  logic [DW-1:0] m_trail = '0;
  bit          m_da = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // Compare every observable output with the model before the clock edge
  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (q.size() != 0);
    check("tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
    if (exp_valid) begin
      check("tdata", 64'(m_axis_tdata), 64'(q[0].data));
      check("tlast", 64'(m_axis_tlast), 64'(q[0].last));
    end
    m_da = evbuf_avail_i & (m_inev | (q.size() <= THR));
    check("data_avail", 64'(data_avail_o), 64'(m_da));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("framing_err", 64'(framing_err_o), 64'(m_ferr));
    check("event_count", 64'(event_count_o), 64'(m_ec & 16'hFFFF));
  endtask

  // Advance the model by one clock using the inputs held across the edge
  task automatic model_update();
    bit old_pend;
    bit cap;
    logic [DW-1:0] w;
    if (rst_i) begin
      q.delete();
      m_wc = 0; m_ec = 0; m_inev = 0; m_ovf = 0; m_ferr = 0; m_trail_pend = 0;
      return;
    end
    old_pend = m_trail_pend;
    m_trail_pend = 1'b0;
    if (q.size() != 0 && m_axis_tready) void'(q.pop_front());
    cap = clk_ce_i & valid_i;
    if (cap) begin
      if (sel_header_i != (m_wc < HDR)) m_ferr = 1'b1;
      w = sel_header_i ? header_dat_i : ram_dat_i;
      if (old_pend) m_ovf = 1'b1;
      else begin
`ifdef UEV_PACKER_TRAILER_EN
        push_beat(w, 1'b0);
`else
        push_beat(w, complete_i);
`endif
      end
      if (complete_i) begin
`ifdef UEV_PACKER_TRAILER_EN
        m_trail = {16'hE7E7, 16'(m_ec), 32'(m_wc + 1)};
        m_trail_pend = 1'b1;
`endif
        m_ec = m_ec + 1;
        m_wc = 0;
        m_inev = 1'b0;
      end else begin
        m_wc = m_wc + 1;
        m_inev = 1'b1;
      end
    end
    if (old_pend) push_beat(m_trail, 1'b1);
  endtask

  task automatic step();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_update();
    #1;
    cyc++;
    clk_ce_i = ~clk_ce_i;
  endtask

  task automatic set_ready(input int rmode);
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'b0;
      2: m_axis_tready = ((cyc / 3) % 2 == 0);
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    valid_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    valid_i = 1'b0;
    m_axis_tready = 1'b1;
    while ((q.size() != 0 || m_trail_pend) && guard < 100) begin
      step();
      guard++;
    end
    step();
    check("drained_tvalid", 64'(m_axis_tvalid), 64'(0));
  endtask

  // One readout-SM event: wait for availability, then present len words on strobe cycles
  task automatic run_event(input int len, input int bad_idx, input int rmode, input int abort_at);
    int guard;
    int i;
    bit started;
    guard = 0;
    started = 1'b0;
    valid_i = 1'b0;
    while (!started && guard < 300) begin
      evbuf_avail_i = ($urandom_range(0, 3) != 0);
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
      started = m_da;
      guard++;
    end
    check("event_start", 64'(started), 64'(1));
    i = 0;
    guard = 0;
    while (i < len && i != abort_at && guard < 2000) begin
      set_ready(rmode);
      evbuf_avail_i = ($urandom_range(0, 3) != 0);
      header_dat_i = {$urandom, $urandom};
      ram_dat_i = {$urandom, $urandom};
      if (clk_ce_i && (rmode != 3 || $urandom_range(0, 3) != 0)) begin
        valid_i = 1'b1;
        sel_header_i = (i < HDR) ^ (i == bad_idx);
        complete_i = (i == len - 1);
        i++;
      end else begin
        valid_i = !clk_ce_i && ($urandom_range(0, 3) == 0);
        sel_header_i = 1'($urandom_range(0, 1));
        complete_i = 1'($urandom_range(0, 1));
      end
      step();
      guard++;
    end
    valid_i = 1'b0;
    complete_i = 1'b0;
  endtask

  initial begin
    int len;
    int bad;
    do_reset();
    do_reset();
    // reset state with evbuf available and an empty FIFO
    evbuf_avail_i = 1'b1;
    step();

    // Idle event: 4 headers + 12 data, free-flowing stream
    run_event(16, -1, 0, -1);
    drain();
    check("ec_after_first", 64'(event_count_o), 64'(1));

    // Full backpressure: the 17th word is dropped and overflow sticks
    run_event(17, -1, 1, -1);
    step();
    check("overflow_set", 64'(overflow_o), 64'(1));
    drain();
    do_reset();

    // Stream stalls every 3 clocks
    run_event(20, -1, 2, -1);
    drain();

    // Framing: 3rd capture flagged as data instead of header, stays sticky
    run_event(8, 2, 0, -1);
    drain();
    run_event(6, -1, 3, -1);
    drain();
    check("framing_sticky", 64'(framing_err_o), 64'(1));
    do_reset();

    // Reset mid-event after 5 buffered words
    run_event(12, -1, 1, 5);
    step();
    do_reset();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_count", 64'(event_count_o), 64'(0));
    evbuf_avail_i = 1'b0;
    step();
    evbuf_avail_i = 1'b1;
    step();

    // Two 8-word events back to back
    run_event(8, -1, 0, -1);
    run_event(8, -1, 0, -1);
    drain();

    // Randomized events with mixed backpressure
    for (int e = 0; e < 40; e++) begin
      len = $urandom_range(1, 24);
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_event(len, bad, $urandom_range(0, 3), -1);
      if ($urandom_range(0, 2) == 0) drain();
      if (e % 10 == 9) do_reset();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
